// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse framer and integrator:
// state encoding, index width, configuration bundle and window helpers.
package pulse_pkg;

    localparam int IDX_W = 16;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    typedef struct packed {
        logic [IDX_W-1:0] n_pulses;
        logic [IDX_W-1:0] n_samples;
        logic [IDX_W-1:0] start_index;
        logic [IDX_W-1:0] end_index;
    } cfg_t;

    // Last forwarded index, clipped to the end of the pulse.
    function automatic logic [IDX_W-1:0] win_end(
        input logic [IDX_W-1:0] end_index,
        input logic [IDX_W-1:0] n_samples
    );
        logic [IDX_W-1:0] last;
        last = n_samples - 16'd1;
        return (end_index < last) ? end_index : last;
    endfunction

    function automatic logic in_win(
        input logic [IDX_W-1:0] idx,
        input logic [IDX_W-1:0] lo,
        input logic [IDX_W-1:0] hi
    );
        return (idx >= lo) && (idx <= hi);
    endfunction

endpackage

// File: rtl/pulse_framer_if.sv
// Output stream bundle of the pulse framer (AXI4-Stream subset).
interface pulse_framer_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         tuser;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module trig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic rise
);
    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= trig;
            s2   <= s1;
            prev <= s2;
            rise <= s2 & ~prev;
        end
    end
endmodule

// File: rtl/pulse_framer.sv
// Cuts the free-running ADC stream into one windowed frame per trigger.
// The source cannot stall, so back-pressure loss is flagged, not absorbed.
module pulse_framer
    import pulse_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       trigger,
    input  logic                       enable,
    input  logic [IDX_W-1:0]           n_pulses,
    input  logic [IDX_W-1:0]           n_samples,
    input  logic [IDX_W-1:0]           start_index,
    input  logic [IDX_W-1:0]           end_index,
    pulse_framer_if.master             m_axis,
    output logic                       busy,
    output logic                       overflow,
    output logic                       missed_trigger,
    output logic [IDX_W-1:0]           pulse_count
);
    logic [1:0]       state;
    cfg_t             cfg;
    logic [IDX_W-1:0] idx;
    logic             trig_edge;

    logic             take;
    logic             fwd;
    logic             pend;
    logic             zero_pulse;
    logic [IDX_W-1:0] eff_end;
    logic [IDX_W-1:0] np_eff;
    logic [1:0]       after;

    trig_sync_edge u_sync (
        .clk  (aclk),
        .rst  (areset),
        .trig (trigger),
        .rise (trig_edge)
    );

    always_comb begin
        eff_end    = win_end(cfg.end_index, cfg.n_samples);
        take       = (state == CAPTURE) && s_axis_tvalid;
        fwd        = take && in_win(idx, cfg.start_index, eff_end);
        pend       = take && (idx == cfg.n_samples - 16'd1);
        zero_pulse = (state == ARM) && enable && trig_edge
                     && (n_samples == '0);
        // An empty pulse finishes while the config is still being latched.
        np_eff     = zero_pulse ? n_pulses : cfg.n_pulses;
        if (!enable || (np_eff != '0
                        && pulse_count + 16'd1 == np_eff))
            after = IDLE;
        else
            after = ARM;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state          <= IDLE;
            cfg            <= '0;
            idx            <= '0;
            pulse_count    <= '0;
            overflow       <= 1'b0;
            missed_trigger <= 1'b0;
            m_axis.tdata   <= '0;
            m_axis.tvalid  <= 1'b0;
            m_axis.tlast   <= 1'b0;
            m_axis.tuser   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state          <= ARM;
                        pulse_count    <= '0;
                        overflow       <= 1'b0;
                        missed_trigger <= 1'b0;
                    end
                end
                ARM: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (trig_edge) begin
                        cfg <= '{n_pulses, n_samples,
                                 start_index, end_index};
                        idx <= '0;
                        if (zero_pulse) begin
                            pulse_count <= pulse_count + 16'd1;
                            state       <= after;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (trig_edge)
                        missed_trigger <= 1'b1;
                    if (take) begin
                        idx <= idx + 16'd1;
                        if (pend) begin
                            pulse_count <= pulse_count + 16'd1;
                            state       <= after;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Single output stage: a stalled beat is never overwritten.
            if (fwd && m_axis.tvalid && !m_axis.tready) begin
                overflow <= 1'b1;
            end else if (fwd) begin
                m_axis.tdata  <= s_axis_tdata;
                m_axis.tvalid <= 1'b1;
                m_axis.tuser  <= (idx == cfg.start_index);
                m_axis.tlast  <= (idx == eff_end);
            end else if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
                m_axis.tuser  <= 1'b0;
                m_axis.tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pulse_framer.sv
// Directed bench: stimulus pushes expected beats, a negedge monitor
// pops and compares every accepted output beat.
module tb_pulse_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        trigger;
    logic        enable;
    logic [15:0] n_pulses;
    logic [15:0] n_samples;
    logic [15:0] start_index;
    logic [15:0] end_index;
    logic        busy;
    logic        overflow;
    logic        missed;
    logic [15:0] pulse_count;

    int vectors = 0;
    int errors  = 0;
    logic [33:0] exp_q[$];

    pulse_framer_if #(.W(32)) m_axis ();

    pulse_framer #(.AXIS_DATA_WIDTH(32)) dut (
        .aclk           (clk),
        .areset         (rst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .trigger        (trigger),
        .enable         (enable),
        .n_pulses       (n_pulses),
        .n_samples      (n_samples),
        .start_index    (start_index),
        .end_index      (end_index),
        .m_axis         (m_axis),
        .busy           (busy),
        .overflow       (overflow),
        .missed_trigger (missed),
        .pulse_count    (pulse_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a beat visible with tready high at negedge transfers
    // on the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && m_axis.tvalid === 1'b1
            && m_axis.tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_beat: got data=%0h user=%0b last=%0b, expected none",
                         m_axis.tdata, m_axis.tuser, m_axis.tlast);
            end else begin
                check("beat", {30'd0, m_axis.tdata, m_axis.tuser,
                               m_axis.tlast},
                      {30'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int np, input int ns, input int st,
                       input int en);
        n_pulses    = np[15:0];
        n_samples   = ns[15:0];
        start_index = st[15:0];
        end_index   = en[15:0];
    endtask

    task automatic push_beat(input int d, input bit u, input bit l);
        exp_q.push_back({d[31:0], u, l});
    endtask

    // Trigger to CAPTURE: 3 cycles to trig_edge, 1 more to enter CAPTURE.
    task automatic fire;
        trigger = 1'b1;
        tick;
        trigger = 1'b0;
        repeat (3) tick;
    endtask

    task automatic feed(input int ns, input int st, input int en,
                        input int rdy_from, input int trig_at,
                        input int drop_at, input bit auto_push);
        int ee;
        ee = (en < ns - 1) ? en : ns - 1;
        for (int i = 0; i < ns; i++) begin
            s_tdata       = i;
            s_tvalid      = 1'b1;
            m_axis.tready = (i >= rdy_from);
            trigger       = (i == trig_at);
            if (i == drop_at)
                enable = 1'b0;
            if (auto_push && i >= st && i <= ee)
                push_beat(i, i == st, i == ee);
            tick;
        end
        s_tvalid      = 1'b0;
        trigger       = 1'b0;
        m_axis.tready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        s_tdata = '0;
        s_tvalid = 1'b0;
        trigger = 1'b0;
        enable = 1'b0;
        m_axis.tready = 1'b1;
        cfg(0, 0, 0, 0);
        repeat (2) tick;
        check("rst_out", {m_axis.tvalid, m_axis.tlast, m_axis.tuser,
                          m_axis.tdata}, 64'd0);
        check("rst_flags", {busy, overflow, missed, pulse_count}, 64'd0);
        rst = 1'b0;
        tick;

        // Two 4-beat frames of a two-pulse burst.
        cfg(2, 8, 2, 5);
        enable = 1'b1;
        tick;
        check("t1_busy", busy, 1);
        fire;
        feed(8, 2, 5, 0, -1, -1, 1);
        check("t1_pc1", pulse_count, 1);
        fire;
        feed(8, 2, 5, 0, -1, -1, 1);
        check("t1_pc2", pulse_count, 2);
        check("t1_idle", busy, 0);
        enable = 1'b0;
        repeat (3) tick;

        // Window end clipped to the pulse length.
        cfg(1, 8, 0, 20);
        enable = 1'b1;
        tick;
        fire;
        feed(8, 0, 20, 0, -1, -1, 1);
        check("t2_pc", pulse_count, 1);
        check("t2_idle", busy, 0);
        enable = 1'b0;
        repeat (3) tick;

        // Empty window: pulses counted, nothing forwarded.
        cfg(2, 8, 6, 3);
        enable = 1'b1;
        tick;
        fire;
        feed(8, 6, 3, 0, -1, -1, 1);
        check("t3_pc1", pulse_count, 1);
        check("t3_busy", busy, 1);
        fire;
        feed(8, 6, 3, 0, -1, -1, 1);
        check("t3_pc2", pulse_count, 2);
        check("t3_idle", busy, 0);
        enable = 1'b0;
        repeat (3) tick;

        // n_samples == 0 completes on the edge-detect cycle.
        cfg(1, 0, 0, 0);
        enable = 1'b1;
        tick;
        check("t3b_pc0", pulse_count, 0);
        fire;
        check("t3b_pc", pulse_count, 1);
        check("t3b_idle", busy, 0);
        enable = 1'b0;
        repeat (3) tick;

        // Back-pressure: first beat held, next two dropped.
        cfg(1, 8, 2, 5);
        enable = 1'b1;
        tick;
        check("t4_ovf0", overflow, 0);
        fire;
        push_beat(2, 1'b1, 1'b0);
        push_beat(5, 1'b0, 1'b1);
        feed(8, 2, 5, 5, -1, -1, 0);
        check("t4_ovf", overflow, 1);
        check("t4_pc", pulse_count, 1);
        enable = 1'b0;
        repeat (3) tick;
        check("t4_sticky", overflow, 1);

        // Trigger during CAPTURE is flagged and ignored.
        cfg(1, 8, 1, 6);
        enable = 1'b1;
        tick;
        check("t5_ovf_clr", overflow, 0);
        check("t5_miss0", missed, 0);
        fire;
        feed(8, 1, 6, 0, 3, -1, 1);
        check("t5_miss", missed, 1);
        check("t5_pc", pulse_count, 1);
        enable = 1'b0;
        repeat (3) tick;

        // Continuous mode, enable dropped during pulse 5.
        cfg(0, 4, 1, 2);
        enable = 1'b1;
        tick;
        for (int p = 0; p < 4; p++) begin
            fire;
            feed(4, 1, 2, 0, -1, -1, 1);
        end
        check("t6_pc4", pulse_count, 4);
        check("t6_busy", busy, 1);
        fire;
        feed(4, 1, 2, 0, -1, 1, 1);
        check("t6_pc5", pulse_count, 5);
        check("t6_idle", busy, 0);
        repeat (3) tick;
        check("t6_stay", busy, 0);

        // Asynchronous reset mid-pulse with a held beat.
        cfg(1, 8, 0, 7);
        enable = 1'b1;
        tick;
        fire;
        m_axis.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tdata  = 32'h100 + i;
            s_tvalid = 1'b1;
            tick;
        end
        check("t7_held", {m_axis.tvalid, m_axis.tdata}, {1'b1, 32'h100});
        check("t7_ovf", overflow, 1);
        rst = 1'b1;
        #2;
        check("t7_rst_out", {m_axis.tvalid, m_axis.tlast, m_axis.tuser,
                             m_axis.tdata}, 64'd0);
        check("t7_rst_flags", {busy, overflow, missed, pulse_count}, 64'd0);
        s_tvalid = 1'b0;
        enable = 1'b0;
        tick;
        rst = 1'b0;
        m_axis.tready = 1'b1;
        repeat (5) tick;

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
